// File: rtl/fir_stim_pkg.sv
// Shared types and helpers for the FIR test-signal generator.
package fir_stim_pkg;

  localparam logic [7:0] LFSR_MASK = 8'hB8;

  typedef enum logic [2:0] {
    IMPULSE = 3'd0,
    STEP    = 3'd1,
    SQUARE  = 3'd2,
    RAMP    = 3'd3,
    NOISE   = 3'd4
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Two's-complement negate; -128 has no positive twin so it clips to +127.
  function automatic logic [7:0] sat_neg(input logic [7:0] a);
    if (a == 8'h80) return 8'h7F;
    return ~a + 8'd1;
  endfunction

endpackage

// File: rtl/fir_stim_lfsr.sv
// 8-bit Galois right-shift LFSR; load has priority over advance.
module fir_stim_lfsr
  import fir_stim_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] value
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  localparam logic [7:0] SEED_SAFE = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED_SAFE;
    end else if (load) begin
      value <= SEED_SAFE;
    end else if (adv) begin
      value <= {1'b0, value[7:1]} ^ (value[0] ? LFSR_MASK : 8'h00);
    end
  end

endmodule

// File: rtl/fir_stim_gen.sv
// Programmable test-signal source for the FIR sample input: impulse, step,
// square, ramp and LFSR noise at a rate of one sample per div+1 clocks.
module fir_stim_gen
  import fir_stim_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] amp,
  input  logic [7:0]        div,
  input  logic [7:0]        half_per,
  input  logic [7:0]        burst_len,
  output logic [DATA_W-1:0] x,
  output logic              x_valid,
  output logic              busy,
  output logic              done,
  output logic              dbg_state
);

  state_e            state_q, state_d;
  logic [2:0]        mode_q;
  logic [DATA_W-1:0] amp_q;
  logic [7:0]        div_q;
  logic [7:0]        hp_q;
  logic [7:0]        len_q;
  logic [7:0]        tick_q;
  logic [7:0]        sent_q;
  logic [7:0]        ph_q;
  logic              pol_q;
  logic              first_q;
  logic              fin_q;
  logic [DATA_W-1:0] acc_q;
  logic [7:0]        lfsr_val;

  logic              emit;
  logic              last;
  logic              lfsr_load;
  logic [DATA_W-1:0] sample;

  fir_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .adv   (emit),
    .value (lfsr_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // stop beats start, start beats the end-of-burst return to IDLE.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    lfsr_load = 1'b0;
    last      = 1'b0;
    sample    = '0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d   = RUN;
      lfsr_load = 1'b1;
    end else if (state_q == RUN) begin
      if (fin_q) state_d = IDLE;
      else       emit    = (tick_q == 8'd0);
    end
    last = (len_q != 8'd0) && ((sent_q + 8'd1) == len_q);
    case (mode_q)
      IMPULSE: sample = first_q ? amp_q : '0;
      STEP:    sample = amp_q;
      SQUARE:  sample = pol_q ? sat_neg(amp_q) : amp_q;
      RAMP:    sample = acc_q;
      NOISE:   sample = lfsr_val;
      default: sample = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      amp_q   <= '0;
      div_q   <= '0;
      hp_q    <= '0;
      len_q   <= '0;
      tick_q  <= '0;
      sent_q  <= '0;
      ph_q    <= '0;
      pol_q   <= 1'b0;
      first_q <= 1'b0;
      fin_q   <= 1'b0;
      acc_q   <= '0;
      x       <= '0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      x_valid <= 1'b0;
      done    <= 1'b0;
      if (stop) begin
        x     <= '0;
        fin_q <= 1'b0;
      end else if (start) begin
        mode_q  <= mode;
        amp_q   <= amp;
        div_q   <= div;
        hp_q    <= (half_per == 8'd0) ? 8'd1 : half_per;
        len_q   <= burst_len;
        tick_q  <= '0;
        sent_q  <= '0;
        ph_q    <= '0;
        pol_q   <= 1'b0;
        first_q <= 1'b1;
        fin_q   <= 1'b0;
        acc_q   <= '0;
      end else if (state_q == RUN) begin
        if (fin_q) begin
          done  <= 1'b1;
          fin_q <= 1'b0;
        end else if (emit) begin
          x       <= sample;
          x_valid <= 1'b1;
          tick_q  <= div_q;
          first_q <= 1'b0;
          sent_q  <= sent_q + 8'd1;
          fin_q   <= last;
          acc_q   <= acc_q + amp_q;
          if ((ph_q + 8'd1) == hp_q) begin
            ph_q  <= '0;
            pol_q <= ~pol_q;
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end else begin
          tick_q <= tick_q - 8'd1;
        end
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_stim_gen.sv
// Self-checking bench for fir_stim_gen: table of waveform vectors plus
// hand sequences for restart, start+stop, LFSR period and async reset.
module tb_fir_stim_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] mode = '0;
  logic [7:0] amp = '0;
  logic [7:0] div = '0;
  logic [7:0] half_per = '0;
  logic [7:0] burst_len = '0;
  logic [7:0] x;
  logic       x_valid;
  logic       busy;
  logic       done;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  amp;
    logic [7:0]  div;
    logic [7:0]  hp;
    logic [7:0]  len;
    int          n;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  fir_stim_gen #(.DATA_W(8), .LFSR_SEED(8'h01)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .amp       (amp),
    .div       (div),
    .half_per  (half_per),
    .burst_len (burst_len),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input logic [2:0] m, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] h, input logic [7:0] l,
                         input int n, input logic [63:0] e);
    vecs[i].mode = m; vecs[i].amp = a; vecs[i].div = d;
    vecs[i].hp = h; vecs[i].len = l; vecs[i].n = n; vecs[i].exp = e;
  endtask

  // driver: called at a negedge; cfg is scrambled afterwards so latching is exercised
  task automatic do_start(input logic [2:0] m, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] h, input logic [7:0] l);
    mode = m; amp = a; div = d; half_per = h; burst_len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 3'($urandom_range(0, 7));
    amp = 8'($urandom_range(0, 255));
    div = 8'($urandom_range(0, 255));
    half_per = 8'($urandom_range(0, 255));
    burst_len = 8'($urandom_range(1, 255));
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [63:0] e;
    logic [7:0] s;
    logic [7:0] last_s;
    int got;
    int gap;
    v = vecs[i];
    e = v.exp;
    got = 0;
    gap = 0;
    for (int k = 0; k < v.n; k++) exp_q.push_back(e[63-8*k -: 8]);
    last_s = e[63-8*(v.n-1) -: 8];
    do_start(v.mode, v.amp, v.div, v.hp, v.len);
    for (int cyc = 0; cyc < 2000 && got < v.n; cyc++) begin
      @(negedge clk);
      gap++;
      if (x_valid) begin
        check($sformatf("v%0d_gap%0d", i, got), gap, (got == 0) ? 1 : int'(v.div) + 1);
        if (got == 0) check($sformatf("v%0d_busy", i), busy, 1);
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_sb_underflow", i), 1, 0);
        end else begin
          s = exp_q.pop_front();
          check($sformatf("v%0d_x%0d", i, got), x, s);
        end
        gap = 0;
        got++;
      end
    end
    check($sformatf("v%0d_count", i), got, v.n);
    if (v.len != 8'd0) begin
      @(negedge clk);
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      check($sformatf("v%0d_x_hold", i), x, last_s);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_no_valid", i), x_valid, 0);
    end else begin
      pulse_stop();
      check($sformatf("v%0d_stop_x", i), x, 0);
      check($sformatf("v%0d_stop_valid", i), x_valid, 0);
      check($sformatf("v%0d_stop_busy", i), busy, 0);
      check($sformatf("v%0d_stop_done", i), done, 0);
    end
    check($sformatf("v%0d_sb_left", i), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] ns[256];
    int got;
    int dup;
    int seen;

    set_vec(0,  3'd0, 8'h40, 8'd0, 8'd0, 8'd4, 4, 64'h40000000_00000000);
    set_vec(1,  3'd2, 8'h10, 8'd1, 8'd2, 8'd0, 8, 64'h1010F0F0_1010F0F0);
    set_vec(2,  3'd3, 8'h60, 8'd2, 8'd0, 8'd4, 4, 64'h0060C020_00000000);
    set_vec(3,  3'd4, 8'h00, 8'd0, 8'd0, 8'd0, 8, 64'h01B85C2E_17B3E1C8);
    set_vec(4,  3'd2, 8'h80, 8'd0, 8'd1, 8'd0, 4, 64'h807F807F_00000000);
    set_vec(5,  3'd1, 8'hA5, 8'd0, 8'd0, 8'd3, 3, 64'hA5A5A500_00000000);
    set_vec(6,  3'd6, 8'h33, 8'd1, 8'd0, 8'd2, 2, 64'h00000000_00000000);
    set_vec(7,  3'd2, 8'h05, 8'd0, 8'd0, 8'd4, 4, 64'h05FB05FB_00000000);
    set_vec(8,  3'd0, 8'h7F, 8'd0, 8'd0, 8'd0, 3, 64'h7F000000_00000000);
    set_vec(9,  3'd4, 8'h00, 8'd3, 8'd0, 8'd2, 2, 64'h01B80000_00000000);
    set_vec(10, 3'd1, 8'h22, 8'd0, 8'd0, 8'd2, 2, 64'h22220000_00000000);

    repeat (2) @(negedge clk);
    check("rst_x", x, 0);
    check("rst_valid", x_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // restart while running: new cfg takes over, ramp state discarded
    do_start(3'd3, 8'h01, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    run_vec(10);

    // start and stop together while running: stop wins
    do_start(3'd2, 8'h80, 8'd0, 8'd1, 8'd0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_x", x, 0);
    check("ss_valid", x_valid, 0);
    check("ss_state", dbg_state, 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (x_valid || done) seen++;
    end
    check("ss_quiet", seen, 0);

    // LFSR period
    do_start(3'd4, 8'h00, 8'd0, 8'd1, 8'd0);
    got = 0;
    for (int cyc = 0; cyc < 1000 && got < 256; cyc++) begin
      @(negedge clk);
      if (x_valid) begin
        ns[got] = x;
        got++;
      end
    end
    check("noise_count", got, 256);
    dup = 0;
    for (int k = 1; k < 255; k++) if (ns[k] == 8'h01) dup++;
    check("noise_early_repeat", dup, 0);
    check("noise_period", ns[255], 8'h01);
    pulse_stop();

    // async reset mid-run, then restart re-emits the seed
    do_start(3'd4, 8'h00, 8'd3, 8'd1, 8'd0);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", x, 0);
    check("arst_valid", x_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
